// File: rtl/raifes_muldiv_if.sv
// raifes_muldiv_if: request/response handshake bundle between the pipeline and the mul/div unit.
interface raifes_muldiv_if #(parameter int XLEN = 32);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_op;
   logic [XLEN-1:0] req_in1;
   logic [XLEN-1:0] req_in2;
   logic            kill;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_result;
   modport master (
      output req_valid, req_op, req_in1, req_in2, kill, resp_ready,
      input  req_ready, resp_valid, resp_result
   );
   modport slave (
      input  req_valid, req_op, req_in1, req_in2, kill, resp_ready,
      output req_ready, resp_valid, resp_result
   );
endinterface

// File: rtl/raifes_muldiv.sv
// raifes_muldiv: iterative RV32M multiply/divide unit, 32 shift-add or
// restoring shift-subtract steps between a one-cycle setup and a one-cycle sign fix-up.
module raifes_muldiv #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 6
) (
   input logic             clk,
   input logic             nreset,
   raifes_muldiv_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, SETUP, COMPUTE, FINAL, DONE} state_t;
   state_t                 r_state, w_next;
   logic [2:0]             r_op;
   logic [XLEN-1:0]        r_in1, r_in2, r_a, r_b, r_quot, r_result;
   logic                   r_s1, r_s2;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [2*XLEN-1:0]      r_prod;
   logic [XLEN:0]          r_rem;
   logic                   w_accept, w_sgn1, w_sgn2, w_neg1, w_neg2, w_div0;
   logic [XLEN-1:0]        w_mag1, w_mag2, w_quot_fix, w_rem_fix, w_final;
   logic [XLEN:0]          w_sum, w_shift, w_diff;
   logic [2*XLEN-1:0]      w_prod_fix;
   assign bus.req_ready   = (r_state == IDLE) && !bus.kill;
   assign bus.resp_valid  = (r_state == DONE);
   assign bus.resp_result = r_result;
   assign w_accept = bus.req_valid && bus.req_ready;
   assign w_sgn1   = (r_op == 3'd1) || (r_op == 3'd2) || (r_op == 3'd4) || (r_op == 3'd6);
   assign w_sgn2   = (r_op == 3'd1) || (r_op == 3'd4) || (r_op == 3'd6);
   assign w_neg1   = w_sgn1 && r_in1[XLEN-1];
   assign w_neg2   = w_sgn2 && r_in2[XLEN-1];
   assign w_mag1   = w_neg1 ? -r_in1 : r_in1;
   assign w_mag2   = w_neg2 ? -r_in2 : r_in2;
   assign w_sum    = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
   // Remainder stays below the divisor, so bit XLEN of the difference is a clean borrow.
   assign w_shift  = {r_rem[XLEN-1:0], r_quot[XLEN-1]};
   assign w_diff   = w_shift - {1'b0, r_b};
   assign w_div0   = (r_in2 == '0);
   assign w_prod_fix = (r_s1 ^ r_s2) ? -r_prod : r_prod;
   assign w_quot_fix = (r_s1 ^ r_s2) ? -r_quot : r_quot;
   assign w_rem_fix  = r_s1 ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
   assign w_final = (r_op == 3'd0) ? r_prod[XLEN-1:0] :
                    !r_op[2]       ? w_prod_fix[2*XLEN-1:XLEN] :
                    !r_op[1]       ? (w_div0 ? '1 : w_quot_fix) :
                                     (w_div0 ? r_in1 : w_rem_fix);
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_state <= IDLE;
      else         r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = w_accept ? SETUP : IDLE;
         SETUP:   w_next = COMPUTE;
         COMPUTE: w_next = (r_cnt == CNT_WIDTH'(1)) ? FINAL : COMPUTE;
         FINAL:   w_next = DONE;
         DONE:    w_next = bus.resp_ready ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
      if (r_state != IDLE && bus.kill) w_next = IDLE;
   end
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_op     <= '0;
         r_in1    <= '0;
         r_in2    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_rem    <= '0;
         r_quot   <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_op  <= bus.req_op;
            r_in1 <= bus.req_in1;
            r_in2 <= bus.req_in2;
         end
         if (r_state == SETUP) begin
            r_s1   <= w_neg1;
            r_s2   <= w_neg2;
            r_a    <= w_mag1;
            r_b    <= w_mag2;
            r_cnt  <= CNT_WIDTH'(XLEN);
            r_prod <= {{XLEN{1'b0}}, w_mag2};
            r_rem  <= '0;
            r_quot <= w_mag1;
         end
         if (r_state == COMPUTE) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
            if (!r_op[2]) begin
               r_prod <= {w_sum, r_prod[XLEN-1:1]};
            end else begin
               r_rem  <= w_diff[XLEN] ? w_shift : w_diff;
               r_quot <= {r_quot[XLEN-2:0], !w_diff[XLEN]};
            end
         end
         if (r_state == FINAL && !bus.kill) r_result <= w_final;
      end
   end
endmodule

// File: tb/tb_raifes_muldiv.sv
// tb_raifes_muldiv: directed-vector bench for the iterative mul/div unit.
module tb_raifes_muldiv;
   logic clk = 1'b0;
   logic nreset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   raifes_muldiv_if bus();
   raifes_muldiv dut (.clk(clk), .nreset(nreset), .bus(bus));
   always #5 clk = ~clk;
   // Caller is at a negedge with the unit idle; returns at the negedge where resp_valid is seen.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_in1   = a;
      bus.req_in2   = b;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      lat = 1;
      while (!bus.resp_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      res = bus.resp_result;
   endtask
   task automatic take_resp();
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask
   task automatic test_reset();
      #2;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
      checks++; if (bus.resp_result !== 32'h0) begin errors++; $display("FAIL reset_resp_result got %h want 0", bus.resp_result); end
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_mul();
      logic [31:0] r; int lat;
      run_op(3'd0, 32'd7, 32'd6, r, lat);
      checks++; if (r !== 32'h0000002A) begin errors++; $display("FAIL mul_7x6 got %h want 0000002a", r); end
      checks++; if (lat !== 35) begin errors++; $display("FAIL mul_latency got %0d want 35", lat); end
      take_resp();
   endtask
   task automatic test_mulh();
      logic [31:0] r; int lat;
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
      checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL mulh got %h want 00000000", r); end
      take_resp();
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
      checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", r); end
      take_resp();
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
      checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", r); end
      take_resp();
      run_op(3'd2, 32'h00000003, 32'h80000000, r, lat);
      checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL mulhsu_pos got %h want 00000001", r); end
      take_resp();
   endtask
   task automatic test_div();
      logic [31:0] r; int lat;
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, r, lat);
      checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2 got %h want fffffffd", r); end
      checks++; if (lat !== 35) begin errors++; $display("FAIL div_latency got %0d want 35", lat); end
      take_resp();
      run_op(3'd6, 32'hFFFFFFF9, 32'd2, r, lat);
      checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
      take_resp();
      run_op(3'd5, 32'hFFFFFFF9, 32'd2, r, lat);
      checks++; if (r !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu got %h want 7ffffffc", r); end
      take_resp();
      run_op(3'd7, 32'd100, 32'd7, r, lat);
      checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want 00000002", r); end
      take_resp();
   endtask
   task automatic test_div0();
      logic [31:0] r; int lat;
      run_op(3'd4, 32'h00001234, 32'h0, r, lat);
      checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by0 got %h want ffffffff", r); end
      checks++; if (lat !== 35) begin errors++; $display("FAIL div0_latency got %0d want 35", lat); end
      take_resp();
      run_op(3'd5, 32'h00001234, 32'h0, r, lat);
      checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by0 got %h want ffffffff", r); end
      take_resp();
      run_op(3'd6, 32'h00001234, 32'h0, r, lat);
      checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL rem_by0 got %h want 00001234", r); end
      take_resp();
      run_op(3'd7, 32'h00001234, 32'h0, r, lat);
      checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL remu_by0 got %h want 00001234", r); end
      take_resp();
      run_op(3'd6, 32'h80000001, 32'h0, r, lat);
      checks++; if (r !== 32'h80000001) begin errors++; $display("FAIL rem_by0_neg got %h want 80000001", r); end
      take_resp();
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, r, lat);
      checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL div_overflow got %h want 80000000", r); end
      take_resp();
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, r, lat);
      checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL rem_overflow got %h want 00000000", r); end
      take_resp();
   endtask
   task automatic test_backpressure();
      logic [31:0] r; int lat; int bad;
      run_op(3'd0, 32'h00012345, 32'h00000010, r, lat);
      checks++; if (r !== 32'h00123450) begin errors++; $display("FAIL bp_mul got %h want 00123450", r); end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_result !== 32'h00123450) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
      take_resp();
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_req_ready got %b want 1", bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_resp_valid got %b want 0", bus.resp_valid); end
      run_op(3'd5, 32'd100, 32'd7, r, lat);
      checks++; if (r !== 32'd14) begin errors++; $display("FAIL b2b_divu got %h want 0000000e", r); end
      checks++; if (lat !== 35) begin errors++; $display("FAIL b2b_latency got %0d want 35", lat); end
      take_resp();
   endtask
   task automatic test_kill();
      logic [31:0] r; int lat; int seen;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd4;
      bus.req_in1   = 32'd100;
      bus.req_in2   = 32'd3;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int i = 1; i <= 10; i++) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL kill_idle got req_ready %b want 1", bus.req_ready); end
      checks++; if (bus.resp_result !== 32'd14) begin errors++; $display("FAIL kill_result got %h want 0000000e", bus.resp_result); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.resp_valid !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_resp got %0d valid cycles want 0", seen); end
      bus.req_valid = 1'b1;
      bus.kill      = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL kill_masks_ready got %b want 0", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.kill      = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL kill_req_not_taken got req_ready %b want 1", bus.req_ready); end
      @(negedge clk);
      run_op(3'd0, 32'd3, 32'd5, r, lat);
      checks++; if (r !== 32'h0000000F) begin errors++; $display("FAIL after_kill_mul got %h want 0000000f", r); end
      take_resp();
   endtask
   task automatic test_reset_mid();
      logic [31:0] r; int lat;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd0;
      bus.req_in1   = 32'd9;
      bus.req_in2   = 32'd9;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int i = 0; i < 12; i++) @(negedge clk);
      #2 nreset = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_req_ready got %b want 1", bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_resp_valid got %b want 0", bus.resp_valid); end
      checks++; if (bus.resp_result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h want 0", bus.resp_result); end
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      run_op(3'd0, 32'hFFFFFFFF, 32'd2, r, lat);
      checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL rst_mid_mul got %h want fffffffe", r); end
      take_resp();
   endtask
   initial begin
      bus.req_valid  = 1'b0;
      bus.req_op     = 3'd0;
      bus.req_in1    = '0;
      bus.req_in2    = '0;
      bus.kill       = 1'b0;
      bus.resp_ready = 1'b0;
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_div0();
      test_backpressure();
      test_kill();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
